gate_sweep_ctrl: RTL and testbench
==================================

# gate_sweep_ctrl

Sequencer that exhaustively drives a small combinational gate under test (e.g. the two-input `a | ~b` cell) through every input combination, waits a programmable settle time per vector, captures the gate output, and compares the captured truth table against an expected one. It sits between a bench or top-level control block and the gate instance, replacing hand-written `#1` stimulus with a clocked, restartable sweep.

## Interface
Parameters:
- `N_IN`, 2: number of gate inputs; legal range 1..6.
- `SETTLE`, 1: cycles each vector is held before sampling; legal range 1..15.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: level-sampled sweep request; honoured only in IDLE.
- `expected` input 2**N_IN: expected truth table, bit i = gate output for stimulus i; latched when `start` is accepted.
- `dut_s` input 1: output of the gate under test.
- `stim` output N_IN: stimulus to the gate; for N_IN=2, `stim[1]`=a, `stim[0]`=b.
- `busy` output 1: sweep in progress.
- `done` output 1: one-cycle pulse, sweep finished.
- `captured` output 2**N_IN: captured truth table.
- `pass` output 1: `captured == expected` for the last completed sweep.
- `fail_idx` output N_IN: lowest stimulus index that mismatched; 0 if none.

## Operation
- States: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE: `stim`=0, `busy`=0, `done`=0. If `start`=1 at an edge: latch `expected`, clear `captured`, `fail_idx`, `pass`, and the internal first-fail flag; `stim`<=0; go to DRIVE.
- DRIVE: hold `stim`; settle counter runs for SETTLE cycles, then go to SAMPLE.
- SAMPLE: at the closing edge, `captured[stim]`<=`dut_s`. If `dut_s` != latched `expected[stim]` and no earlier mismatch occurred, `fail_idx`<=`stim` and set the first-fail flag. If `stim` == 2**N_IN-1, go to FINISH with `pass`<=(final captured == latched expected); otherwise `stim`<=`stim`+1 and return to DRIVE.
- FINISH: `done`=1, `busy`=0 for exactly one cycle, then IDLE. `stim` stays at the last vector during FINISH and returns to 0 in IDLE.
- `busy`=1 exactly in DRIVE and SAMPLE.
- `start` in DRIVE, SAMPLE, or FINISH is ignored and is not queued. If `start` is still high in IDLE, a new sweep begins on the next edge.
- `captured`, `pass`, and `fail_idx` hold their values from FINISH until the next accepted `start` or `reset`.
- Width rules: the stimulus counter is N_IN bits and does not wrap during a sweep because the last vector exits to FINISH. The settle counter is 4 bits.

## Timing
- Reset: after any edge with `reset`=1, the state is IDLE and `stim`, `busy`, `done`, `captured`, `pass`, and `fail_idx` are all 0. `reset` overrides `start` and any in-flight sweep. An aborted sweep produces no `done`.
- Per vector: SETTLE+1 cycles, made up of SETTLE cycles in DRIVE and 1 in SAMPLE. `dut_s` is sampled SETTLE+1 edges after `stim` changes.
- Start-to-done latency: if `start` is accepted at edge k, `done` is high in the cycle following edge k + 2**N_IN·(SETTLE+1).
- `busy` rises after edge k and falls in the same cycle `done` rises.
- Minimum start-to-start interval: 2**N_IN·(SETTLE+1)+2 cycles. This covers the sweep, one cycle of FINISH, and one cycle of IDLE.

## Test plan
- Reset: hold `reset` for 2 cycles with `start`=1. Required: every output is 0, `busy` never rises, and `stim`=0.
- Nominal pass: N_IN=2, SETTLE=1, DUT = `a | ~b`, `expected`=4'b1101, pulse `start`. Required:
  - `stim` sequence is 0,0,1,1,2,2,3,3.
  - `done` is high 8 cycles after the start edge.
  - `captured`=4'b1101, `pass`=1, `fail_idx`=0.
- Mismatch: same DUT, `expected`=4'b1111. Required: `captured`=4'b1101, `pass`=0, `fail_idx`=1. With `expected`=4'b0101, `fail_idx`=3.
- Start during busy: hold `start` high continuously. Required:
  - No restart during the sweep.
  - `done` pulses once, followed by one IDLE cycle with `stim`=0.
  - A second sweep then starts, and its `done` arrives 10 cycles after the first `done`.
- Reset mid-sweep: assert `reset` while `stim`=2. Required: on the next cycle all outputs are 0, no `done` pulse occurs, and a following `start` runs a complete correct sweep.
- Parameter check: SETTLE=3, N_IN=2. Required: each `stim` value is held 4 cycles, and `done` arrives 16 cycles after the start edge with the same captured value 4'b1101.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: clocked exhaustive sweep of a small combinational gate.
// Walks every input vector, holds each one for SETTLE cycles, samples the
// gate output into a captured truth table and compares it to the expected one.
//
// Handshake: start is level-sampled and only acted on in IDLE; done is a
// single-cycle pulse in FINISH, and the results (captured/pass/fail_idx) stay
// valid from that pulse until the next accepted start or reset.
module gate_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_s,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   captured,
    output logic                 pass,
    output logic [N_IN-1:0]      fail_idx,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    // Settle counter runs 0..SETTLE-1 while in DRIVE.
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] STIM_LAST   = {N_IN{1'b1}};

    state_t              state;
    state_t              state_nx;
    logic [3:0]          settle_cnt;
    logic [2**N_IN-1:0]  exp_lat;
    logic [2**N_IN-1:0]  cap_nx;
    logic                first_fail;
    logic                mismatch;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: one DRIVE/SAMPLE pair per vector, last vector exits.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_DRIVE;
            S_DRIVE:  if (settle_cnt == SETTLE_LAST) state_nx = S_SAMPLE;
            S_SAMPLE: state_nx = (stim == STIM_LAST) ? S_FINISH : S_DRIVE;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded purely from the current state.
    always_comb begin
        busy      = (state == S_DRIVE) || (state == S_SAMPLE);
        done      = (state == S_FINISH);
        state_dbg = state;
    end

    // Captured table with the current sample merged in, and the per-vector compare.
    always_comb begin
        cap_nx       = captured;
        cap_nx[stim] = dut_s;
        mismatch     = (dut_s != exp_lat[stim]);
    end

    // Settle counter: counts DRIVE cycles, cleared everywhere else.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= 4'd0;
        end else if (state == S_DRIVE && settle_cnt != SETTLE_LAST) begin
            settle_cnt <= settle_cnt + 4'd1;
        end else begin
            settle_cnt <= 4'd0;
        end
    end

    // Sweep datapath: stimulus counter, capture, first-fail tracking, verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            stim       <= '0;
            captured   <= '0;
            exp_lat    <= '0;
            pass       <= 1'b0;
            fail_idx   <= '0;
            first_fail <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        exp_lat    <= expected;
                        captured   <= '0;
                        pass       <= 1'b0;
                        fail_idx   <= '0;
                        first_fail <= 1'b0;
                        stim       <= '0;
                    end
                end
                S_SAMPLE: begin
                    captured <= cap_nx;
                    if (mismatch && !first_fail) begin
                        fail_idx   <= stim;
                        first_fail <= 1'b1;
                    end
                    if (stim == STIM_LAST) begin
                        // Verdict uses the table including this last sample.
                        pass <= (cap_nx == exp_lat);
                    end else begin
                        stim <= stim + N_IN'(1);
                    end
                end
                S_FINISH: begin
                    // Last vector is held through FINISH, then drops to 0 for IDLE.
                    stim <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) each driving
// an a | ~b gate model; expected stimulus per cycle is queued and popped.
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start3;
    logic [3:0] expected1, expected3;
    logic       dut_s1, dut_s3;
    logic [1:0] stim1, stim3;
    logic       busy1, busy3, done1, done3, pass1, pass3;
    logic [3:0] captured1, captured3;
    logic [1:0] fail_idx1, fail_idx3;
    logic [1:0] st1, st3;

    int n_checks = 0;
    int n_errs   = 0;
    logic [1:0] exp_q[$];

    // clock / gate models
    always #5 clk = ~clk;
    assign dut_s1 = stim1[1] | ~stim1[0];
    assign dut_s3 = stim3[1] | ~stim3[0];

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .expected(expected1),
        .dut_s(dut_s1), .stim(stim1), .busy(busy1), .done(done1),
        .captured(captured1), .pass(pass1), .fail_idx(fail_idx1), .state_dbg(st1)
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .expected(expected3),
        .dut_s(dut_s3), .stim(stim3), .busy(busy3), .done(done3),
        .captured(captured3), .pass(pass3), .fail_idx(fail_idx3), .state_dbg(st3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] g_stim(input int sel);
        return (sel == 0) ? stim1 : stim3;
    endfunction
    function automatic logic g_busy(input int sel);
        return (sel == 0) ? busy1 : busy3;
    endfunction
    function automatic logic g_done(input int sel);
        return (sel == 0) ? done1 : done3;
    endfunction

    // Follows one sweep from its accepting edge through the done cycle.
    // Caller has already driven start/expected before the accepting edge.
    task automatic track(input int sel, input int settle, input bit hold,
                         input logic [3:0] e_cap, input logic e_pass,
                         input logic [1:0] e_fail, output time t_done);
        for (int v = 0; v < 4; v++)
            for (int r = 0; r <= settle; r++)
                exp_q.push_back(2'(v));
        @(posedge clk);
        for (int c = 0; c < 4 * (settle + 1); c++) begin
            @(negedge clk);
            if (!hold) begin
                if (sel == 0) start1 = 1'b0; else start3 = 1'b0;
            end
            chk($sformatf("busy[%0d]", c), g_busy(sel), 1'b1);
            chk($sformatf("stim[%0d]", c), g_stim(sel), exp_q.pop_front());
            chk($sformatf("done_early[%0d]", c), g_done(sel), 1'b0);
        end
        @(negedge clk);
        t_done = $time;
        chk("done_pulse", g_done(sel), 1'b1);
        chk("busy_fin", g_busy(sel), 1'b0);
        chk("stim_fin", g_stim(sel), 2'd3);
        chk("captured", (sel == 0) ? captured1 : captured3, e_cap);
        chk("pass", (sel == 0) ? pass1 : pass3, e_pass);
        chk("fail_idx", (sel == 0) ? fail_idx1 : fail_idx3, e_fail);
    endtask

    // Done-to-IDLE cycle checks after a non-held sweep.
    task automatic idle_after(input int sel, input logic [3:0] e_cap);
        @(negedge clk);
        chk("idle_done", g_done(sel), 1'b0);
        chk("idle_busy", g_busy(sel), 1'b0);
        chk("idle_stim", g_stim(sel), 2'd0);
        chk("cap_hold", (sel == 0) ? captured1 : captured3, e_cap);
    endtask

    initial begin
        time t1, t2;
        logic seen;

        // Reset held 2 cycles with start high on both instances.
        reset = 1'b1; start1 = 1'b1; start3 = 1'b1;
        expected1 = 4'b1101; expected3 = 4'b1101;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_stim", {stim1, stim3}, 4'd0);
            chk("rst_busy", {busy1, busy3}, 2'd0);
            chk("rst_done", {done1, done3}, 2'd0);
            chk("rst_cap", {captured1, captured3}, 8'd0);
            chk("rst_pass", {pass1, pass3}, 2'd0);
            chk("rst_fidx", {fail_idx1, fail_idx3}, 4'd0);
            chk("rst_state", st1, 2'd0);
        end
        reset = 1'b0; start1 = 1'b0; start3 = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy1, 1'b0);

        // Nominal pass.
        start1 = 1'b1; expected1 = 4'b1101;
        track(0, 1, 1'b0, 4'b1101, 1'b1, 2'd0, t1);
        idle_after(0, 4'b1101);

        // Mismatch, first failing index 1.
        @(negedge clk);
        start1 = 1'b1; expected1 = 4'b1111;
        track(0, 1, 1'b0, 4'b1101, 1'b0, 2'd1, t1);
        idle_after(0, 4'b1101);

        // Mismatch, first failing index 3.
        @(negedge clk);
        start1 = 1'b1; expected1 = 4'b0101;
        track(0, 1, 1'b0, 4'b1101, 1'b0, 2'd3, t1);
        idle_after(0, 4'b1101);
        @(negedge clk);
        chk("pass_hold", pass1, 1'b0);
        chk("fidx_hold", fail_idx1, 2'd3);

        // Start held high: one done, one IDLE cycle, then a second sweep.
        start1 = 1'b1; expected1 = 4'b1101;
        track(0, 1, 1'b1, 4'b1101, 1'b1, 2'd0, t1);
        @(negedge clk);
        chk("held_idle_stim", stim1, 2'd0);
        chk("held_idle_busy", busy1, 1'b0);
        chk("held_idle_done", done1, 1'b0);
        track(0, 1, 1'b1, 4'b1101, 1'b1, 2'd0, t2);
        start1 = 1'b0;
        chk("done_gap", 32'((t2 - t1) / 10), 32'd10);
        idle_after(0, 4'b1101);

        // Reset while stim == 2.
        @(negedge clk);
        start1 = 1'b1; expected1 = 4'b1101;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start1 = 1'b0;
        end
        chk("pre_abort_stim", stim1, 2'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out", {stim1, busy1, done1, captured1, pass1, fail_idx1}, 11'd0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done1 || busy1) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);
        start1 = 1'b1; expected1 = 4'b1101;
        track(0, 1, 1'b0, 4'b1101, 1'b1, 2'd0, t1);
        idle_after(0, 4'b1101);

        // SETTLE=3 instance: each vector held 4 cycles, done 16 cycles after start.
        @(negedge clk);
        start3 = 1'b1; expected3 = 4'b1101;
        t2 = $time;
        track(1, 3, 1'b0, 4'b1101, 1'b1, 2'd0, t1);
        chk("s3_latency", 32'((t1 - t2) / 10), 32'd17);
        idle_after(1, 4'b1101);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    // Global time limit in case the stimulus sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
